// File: rtl/sync_fifo_init_ctrl.sv
// FIFO controller over a 1-cycle-latency dual-port RAM; optional index-fill sweep after reset (free-address pool).
// Pop data valid one cycle after accept; pushes rejected when full unless a pop frees a slot in the same cycle.
module sync_fifo_init_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter bit INIT_FULL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  init_done,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RST_STATE = INIT_FULL ? S_INIT : S_RUN;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  push_acc, pop_acc, sweep_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_STATE;
      init_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pop_valid <= pop_acc;
      if (state == S_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (sweep_last) count <= FULL_CNT;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + 1'b1;
        if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
        count <= count_nxt;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    full       = 1'b1;
    empty      = 1'b1;
    push_acc   = 1'b0;
    pop_acc    = 1'b0;
    sweep_last = 1'b0;
    overflow   = 1'b0;
    underflow  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = wr_ptr;
    ram_raddr  = rd_ptr;
    ram_din    = push_data;
    count_nxt  = count;
    case (state)
      S_INIT: begin
        // Each address gets its own index, so the pool starts holding every buffer id.
        ram_we     = 1'b1;
        ram_waddr  = init_cnt;
        ram_din    = DATA_WIDTH'(init_cnt);
        sweep_last = &init_cnt;
        if (sweep_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
        push_acc  = push & (~full | pop);
        pop_acc   = pop & ~empty;
        ram_we    = push_acc;
        ram_re    = pop_acc;
        overflow  = push & ~push_acc;
        underflow = pop & ~pop_acc;
        case ({push_acc, pop_acc})
          2'b10:   count_nxt = count + 1'b1;
          2'b01:   count_nxt = count - 1'b1;
          default: count_nxt = count;
        endcase
      end
    endcase
  end

  assign init_done = (state == S_RUN);
  assign pop_data  = ram_dout;

endmodule
